// File: rtl/full_adder_unit.sv
// -----------------------------------------------------------------------------
// full_adder_unit
//
// Parameterisable-width ripple-carry full adder. At WIDTH=1 this is the
// canonical 1-bit full adder cell. The combinational results drive datapath
// logic with zero latency. A one-cycle registered copy is also provided, with
// a valid flag, for pipelined consumers.
//
// Parameters:
//   WIDTH     - operand and sum width in bits (>= 1)
//
// Ports:
//   clk       - system clock; registered outputs update on the rising edge
//   rst       - synchronous, active-high reset
//   A, B      - operands (unsigned; two's-complement view used for Ovf)
//   Cin       - carry-in, added at bit 0
//   in_valid  - qualifies A/B/Cin for capture into the registered path
//   Sum       - combinational (A + B + Cin) mod 2^WIDTH
//   Cout      - combinational carry out of the MSB
//   Ovf       - combinational signed overflow (carry into MSB ^ carry out)
//   Sum_r     - registered Sum
//   Cout_r    - registered Cout
//   Ovf_r     - registered Ovf
//   out_valid - registered result valid
//
// Handshake: a result is transferred on every rising edge where in_valid is
// high; there is no ready, so the consumer must accept each out_valid pulse
// in the cycle it is presented. out_valid is high for exactly one cycle per
// accepted input, and Sum_r/Cout_r/Ovf_r hold their last value otherwise.
// -----------------------------------------------------------------------------
module full_adder_unit #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf,
    output logic [WIDTH-1:0] Sum_r,
    output logic             Cout_r,
    output logic             Ovf_r,
    output logic             out_valid
);

    // w_carry[i] is the carry into bit i; w_carry[WIDTH] is the carry out.
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_valid;

    // Ripple chain evaluated bit by bit from the LSB inside one block, so
    // each carry is consumed only after it has been produced.
    always_comb begin
        w_carry    = '0;
        w_sum      = '0;
        w_carry[0] = Cin;
        for (int i = 0; i < WIDTH; i++) begin
            w_sum[i]       = A[i] ^ B[i] ^ w_carry[i];
            w_carry[i + 1] = (A[i] & B[i]) | (A[i] & w_carry[i]) | (B[i] & w_carry[i]);
        end
    end

    // Signed overflow: carry into the MSB disagrees with carry out of it.
    // At WIDTH=1 the carry into the MSB is Cin itself.
    assign w_ovf = w_carry[WIDTH] ^ w_carry[WIDTH-1];

    assign Sum  = w_sum;
    assign Cout = w_carry[WIDTH];
    assign Ovf  = w_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end else if (in_valid) begin
            r_sum   <= w_sum;
            r_cout  <= w_carry[WIDTH];
            r_ovf   <= w_ovf;
            r_valid <= 1'b1;
        end else begin
            // Data holds; only the valid flag drops.
            r_valid <= 1'b0;
        end
    end

    assign Sum_r     = r_sum;
    assign Cout_r    = r_cout;
    assign Ovf_r     = r_ovf;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_full_adder_unit.sv
// -----------------------------------------------------------------------------
// tb_full_adder_unit
//
// Drives a WIDTH=1 and a WIDTH=4 instance side by side from shared control
// (rst, in_valid, Cin). The reference model works with plain integer
// arithmetic: unsigned sum for Sum/Cout and a signed-range test for Ovf.
// Inputs change on the falling edge; registered outputs are sampled 2 ns
// after the rising edge.
// -----------------------------------------------------------------------------
module tb_full_adder_unit;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       cin;
    logic       a1, b1;
    logic [3:0] a4, b4;

    logic       sum1, cout1, ovf1, sumr1, coutr1, ovfr1, vld1;
    logic [3:0] sum4, sumr4;
    logic       cout4, ovf4, coutr4, ovfr4, vld4;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-cycle expected registered state: {valid, sum, cout, ovf}
    logic [6:0] st4_q[$];
    logic [3:0] st1_q[$];
    // Expected data of each valid result, in order: {sum, cout, ovf}
    logic [5:0] exp4_q[$];
    logic [2:0] exp1_q[$];

    // Model of the registered state after the next rising edge
    logic [6:0] m4;
    logic [3:0] m1;

    logic [6:0] e4;
    logic [3:0] e1;
    logic [5:0] d4;
    logic [2:0] d1;

    full_adder_unit #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .Cin(cin), .in_valid(in_valid),
        .Sum(sum1), .Cout(cout1), .Ovf(ovf1),
        .Sum_r(sumr1), .Cout_r(coutr1), .Ovf_r(ovfr1), .out_valid(vld1)
    );

    full_adder_unit #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .A(a4), .B(b4), .Cin(cin), .in_valid(in_valid),
        .Sum(sum4), .Cout(cout4), .Ovf(ovf4),
        .Sum_r(sumr4), .Cout_r(coutr4), .Ovf_r(ovfr4), .out_valid(vld4)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk      = 1'b0;
        rst      = 1'b1;
        in_valid = 1'b0;
        cin      = 1'b0;
        a1       = 1'b0;
        b1       = 1'b0;
        a4       = 4'd0;
        b4       = 4'd0;
        m4       = '0;
        m1       = '0;
    end
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic void model(input int w, input int a, input int b, input int c,
                                  output int s, output int co, output int ov);
        int u, sa, sb, t;
        u  = a + b + c;
        s  = u % (1 << w);
        co = (u >= (1 << w)) ? 1 : 0;
        sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
        sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
        t  = sa + sb + c;
        ov = (t > (1 << (w - 1)) - 1 || t < -(1 << (w - 1))) ? 1 : 0;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic r, input logic v, input logic [3:0] a4v,
                         input logic [3:0] b4v, input logic a1v, input logic b1v,
                         input logic cv);
        int s, co, ov;
        @(negedge clk);
        rst = r; in_valid = v; a4 = a4v; b4 = b4v; a1 = a1v; b1 = b1v; cin = cv;
        #1;
        model(4, int'(a4v), int'(b4v), int'(cv), s, co, ov);
        check("comb4_sum",  {4'b0, sum4},  8'(s));
        check("comb4_cout", {7'b0, cout4}, 8'(co));
        check("comb4_ovf",  {7'b0, ovf4},  8'(ov));
        if (r)      m4 = '0;
        else if (v) m4 = {1'b1, 4'(s), 1'(co), 1'(ov)};
        else        m4[6] = 1'b0;
        st4_q.push_back(m4);
        if (!r && v) exp4_q.push_back(m4[5:0]);

        model(1, int'(a1v), int'(b1v), int'(cv), s, co, ov);
        check("comb1_sum",  {7'b0, sum1},  8'(s));
        check("comb1_cout", {7'b0, cout1}, 8'(co));
        check("comb1_ovf",  {7'b0, ovf1},  8'(ov));
        if (r)      m1 = '0;
        else if (v) m1 = {1'b1, 1'(s), 1'(co), 1'(ov)};
        else        m1[3] = 1'b0;
        st1_q.push_back(m1);
        if (!r && v) exp1_q.push_back(m1[2:0]);
    endtask

    task automatic drive_rand(input logic r, input logic v);
        drive(r, v, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (st4_q.size() > 0) begin
                e4 = st4_q.pop_front();
                check("reg4_valid", {7'b0, vld4},   {7'b0, e4[6]});
                check("reg4_sum",   {4'b0, sumr4},  {4'b0, e4[5:2]});
                check("reg4_cout",  {7'b0, coutr4}, {7'b0, e4[1]});
                check("reg4_ovf",   {7'b0, ovfr4},  {7'b0, e4[0]});
            end
            if (vld4 === 1'b1) begin
                if (exp4_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL sb4_empty: got out_valid=1 expected no result at %0t", $time);
                end else begin
                    d4 = exp4_q.pop_front();
                    check("sb4_data", {2'b0, sumr4, coutr4, ovfr4}, {2'b0, d4});
                end
            end
            if (st1_q.size() > 0) begin
                e1 = st1_q.pop_front();
                check("reg1_valid", {7'b0, vld1},   {7'b0, e1[3]});
                check("reg1_sum",   {7'b0, sumr1},  {7'b0, e1[2]});
                check("reg1_cout",  {7'b0, coutr1}, {7'b0, e1[1]});
                check("reg1_ovf",   {7'b0, ovfr1},  {7'b0, e1[0]});
            end
            if (vld1 === 1'b1) begin
                if (exp1_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL sb1_empty: got out_valid=1 expected no result at %0t", $time);
                end else begin
                    d1 = exp1_q.pop_front();
                    check("sb1_data", {5'b0, sumr1, coutr1, ovfr1}, {5'b0, d1});
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // WIDTH=1 truth table {Sum, Cout} indexed by {A, B, Cin}
    logic [1:0] tt [8];
    // WIDTH=4 directed cases {A, B, Cin, Sum, Cout, Ovf}
    logic [14:0] dir4 [4];
    logic [2:0]  abc;
    logic [14:0] dv;

    initial begin
        tt[0] = 2'b00; tt[1] = 2'b10; tt[2] = 2'b10; tt[3] = 2'b01;
        tt[4] = 2'b10; tt[5] = 2'b01; tt[6] = 2'b01; tt[7] = 2'b11;
        dir4[0] = {4'd15, 4'd0,  1'b1, 4'd0,  1'b1, 1'b0};
        dir4[1] = {4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0};
        dir4[2] = {4'd7,  4'd0,  1'b1, 4'd8,  1'b0, 1'b1};
        dir4[3] = {4'd8,  4'd8,  1'b0, 4'd0,  1'b1, 1'b1};

        // Reset for two cycles, then a single WIDTH=1 transaction 1+0+1
        drive_rand(1'b1, 1'b0);
        drive_rand(1'b1, 1'b1);
        drive(1'b0, 1'b1, 4'd3, 4'd4, 1'b1, 1'b0, 1'b1);
        drive_rand(1'b0, 1'b0);
        drive_rand(1'b0, 1'b0);

        // Exhaustive WIDTH=1 sweep, each combination held for 20 ns
        for (int k = 0; k < 8; k++) begin
            abc = 3'(k);
            repeat (2) begin
                drive(1'b0, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      abc[2], abc[1], abc[0]);
                check("tt1_sum",  {7'b0, sum1},  {7'b0, tt[k][1]});
                check("tt1_cout", {7'b0, cout1}, {7'b0, tt[k][0]});
            end
        end

        // WIDTH=4 wrap-around and signed overflow cases
        for (int k = 0; k < 4; k++) begin
            dv = dir4[k];
            drive(1'b0, 1'b1, dv[14:11], dv[10:7], 1'b0, 1'b0, dv[6]);
            check("dir4_sum",  {4'b0, sum4},  {4'b0, dv[5:2]});
            check("dir4_cout", {7'b0, cout4}, {7'b0, dv[1]});
            check("dir4_ovf",  {7'b0, ovf4},  {7'b0, dv[0]});
        end
        drive_rand(1'b0, 1'b0);

        // Reset in the middle of a back-to-back valid stream
        repeat (5) drive_rand(1'b0, 1'b1);
        drive_rand(1'b1, 1'b1);
        repeat (5) drive_rand(1'b0, 1'b1);

        // Combinational outputs must track inputs while held in reset
        repeat (10) drive_rand(1'b1, 1'b0);

        // Random traffic with occasional reset
        repeat (300) drive_rand(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) != 0));
        drive_rand(1'b0, 1'b0);

        // Drain, bounded
        for (int i = 0; i < 20 && (st4_q.size() != 0 || st1_q.size() != 0); i++)
            @(posedge clk);
        #3;
        check("drain_st4",  8'(st4_q.size()),  8'd0);
        check("drain_st1",  8'(st1_q.size()),  8'd0);
        check("drain_exp4", 8'(exp4_q.size()), 8'd0);
        check("drain_exp1", 8'(exp1_q.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/full_adder_unit.md
# full_adder_unit

Module `full_adder`: a single-bit (parameterisable-width) binary full adder producing Sum and carry-out from operands A, B and carry-in Cin. It drives combinational results for immediate use by surrounding datapath logic. It also provides a one-cycle registered copy with a valid flag for pipelined consumers. At the default WIDTH=1 it is the canonical 1-bit full adder cell used to build ripple-carry adders.

## Interface

Parameters:
- WIDTH, default 1: operand and sum width in bits; must be ≥ 1.

Ports:
- clk  input  1  system clock; all registered outputs update on the rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- A  input  WIDTH  operand A (unsigned; also interpreted as two's-complement for Ovf).
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in, added at bit 0.
- in_valid  input  1  qualifies A/B/Cin for capture into the registered path.
- Sum  output  WIDTH  combinational sum, (A + B + Cin) mod 2^WIDTH.
- Cout  output  1  combinational carry-out of the MSB.
- Ovf  output  1  combinational signed overflow: carry into MSB XOR carry out of MSB.
- Sum_r  output  WIDTH  registered Sum.
- Cout_r  output  1  registered Cout.
- Ovf_r  output  1  registered Ovf.
- out_valid  output  1  registered result valid.

## Operation

- Per-bit logic, ripple from bit 0 upward, with c[0] = Cin:
  - s[i] = A[i] ^ B[i] ^ c[i]
  - c[i+1] = (A[i] & B[i]) | (A[i] & c[i]) | (B[i] & c[i])
- Cout = c[WIDTH]; Sum = s[WIDTH-1:0].
- Ovf = c[WIDTH] ^ c[WIDTH-1]. At WIDTH=1, c[0] = Cin, so Ovf = Cout ^ Cin.
- Arithmetic identity: {Cout, Sum} = A + B + Cin, computed in WIDTH+1 bits. No saturation; results wrap modulo 2^WIDTH.
- WIDTH=1 truth table as (A, B, Cin → Sum, Cout):
  - 000 → 0, 0
  - 001, 010, 100 → 1, 0
  - 011, 101, 110 → 0, 1
  - 111 → 1, 1
- Combinational outputs (Sum, Cout, Ovf) depend only on A, B and Cin. They are unaffected by clk, rst and in_valid.
- Registered path, at each rising clk edge:
  - If rst = 1: Sum_r, Cout_r, Ovf_r and out_valid are cleared to 0.
  - Else if in_valid = 1: Sum_r, Cout_r and Ovf_r load the current combinational results, and out_valid is set to 1.
  - Else: Sum_r, Cout_r and Ovf_r hold their previous values, and out_valid is set to 0.
- No backpressure; a new result may be accepted every cycle.
- X or Z on any input propagates naturally; no special handling is required.

## Timing

- Combinational path: Sum, Cout and Ovf settle within the propagation delay after any input change. There are zero clock cycles of latency.
- Registered path: latency of exactly 1 cycle from an in_valid sample to out_valid and the matching Sum_r, Cout_r and Ovf_r.
- Reset values: Sum_r = 0, Cout_r = 0, Ovf_r = 0, out_valid = 0. Combinational outputs have no reset value.
- Reset asserted mid-stream:
  - A result captured at the edge where rst = 1 is discarded.
  - out_valid is 0 in the following cycle, even if in_valid = 1 at that edge.
- After rst deasserts, the first edge with in_valid = 1 produces out_valid = 1 one cycle later.
- Back-to-back valid inputs produce back-to-back valid outputs, in order, with no bubbles.

## Test plan

- WIDTH=1, exhaustive sweep: apply all 8 {A,B,Cin} combinations, 000 through 111, holding each for 20 ns. Sum and Cout must match the truth table, e.g. 011 → Sum=0, Cout=1 and 111 → Sum=1, Cout=1.
- WIDTH=1 registered path:
  - Apply rst=1 for 2 cycles; then A=1, B=0, Cin=1 with in_valid=1 for one cycle.
  - Required: all registered outputs are 0 during reset.
  - The next cycle shows out_valid=1, Sum_r=0, Cout_r=1; the cycle after shows out_valid=0 with Sum_r/Cout_r held.
- WIDTH=4 wrap-around:
  - A=15, B=0, Cin=1 → Sum=0, Cout=1, Ovf=0.
  - A=15, B=15, Cin=1 → Sum=15, Cout=1.
- WIDTH=4 signed overflow:
  - A=7, B=0, Cin=1 → Sum=8, Cout=0, Ovf=1.
  - A=8, B=8, Cin=0 → Sum=0, Cout=1, Ovf=1.
- Reset mid-stream: stream in_valid=1 with changing operands and assert rst for one cycle. Required: out_valid=0 and registered outputs are 0 the cycle after the reset edge, and valid results resume one cycle after the first post-reset valid input.
- Combinational independence: hold rst=1 and in_valid=0, and toggle A, B and Cin. Sum, Cout and Ovf must still track the inputs correctly.
